demux_sched: RTL and testbench

Round-robin scheduler that distributes a single valid/ready input stream across the eight outputs of the 1-to-8 demultiplexer datapath. It picks the destination lane for each accepted beat, holds the beat in a one-entry output register, and presents it on the selected lane with a one-hot valid. It sits between a single producer and eight lane consumers, each with its own ready.

---
 rtl/demux_sched.sv | 94 +++++++++
 tb/tb_demux_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_sched.sv
// demux_sched: round-robin scheduler spreading one valid/ready stream over 8 demux lanes.
// Build macro DEMUX_SCHED_SKIP_EN: lane selection skips lanes whose consumer is not ready.
module demux_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   lane_en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [W-1:0] out_data,
  output logic [2:0]   out_sel
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state, state_next;
  logic [2:0]     ptr, ptr_next;
  logic [2:0]     sel_next;
  logic [W-1:0]   data_next;
  logic [2:0]     sel, sel_en, idx;
  logic           accept, deliver;

`ifdef DEMUX_SCHED_SKIP_EN
  logic [2:0]     sel_rdy;
  logic           found_rdy;
`endif

  // Descending search so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    sel_en = ptr;
    idx    = ptr;
`ifdef DEMUX_SCHED_SKIP_EN
    sel_rdy   = ptr;
    found_rdy = 1'b0;
`endif
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (lane_en[idx]) begin
        sel_en = idx;
      end
`ifdef DEMUX_SCHED_SKIP_EN
      if (lane_en[idx] && out_ready[idx]) begin
        sel_rdy   = idx;
        found_rdy = 1'b1;
      end
`endif
    end
`ifdef DEMUX_SCHED_SKIP_EN
    sel = found_rdy ? sel_rdy : sel_en;
`else
    sel = sel_en;
`endif
  end

  assign in_ready  = (lane_en != 8'h00) && ((state == EMPTY) || out_ready[out_sel]);
  assign accept    = in_valid && in_ready;
  assign deliver   = (state == FULL) && out_ready[out_sel];
  assign out_valid = (state == FULL) ? (8'h01 << out_sel) : 8'h00;

  // A held beat is only released by its own lane; accept may refill it in the same cycle.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    data_next  = out_data;
    sel_next   = out_sel;
    if (accept) begin
      state_next = FULL;
      data_next  = in_data;
      sel_next   = sel;
      ptr_next   = sel + 3'd1;
    end else if (deliver) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      ptr      <= 3'd0;
      out_data <= '0;
      out_sel  <= 3'd0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      out_data <= data_next;
      out_sel  <= sel_next;
    end
  end

endmodule

// File: tb/tb_demux_sched.sv
// tb_demux_sched: scoreboard bench for demux_sched; expected lane/data pushed at drive time.
// Also handles the DEMUX_SCHED_SKIP_EN build when that macro is defined.
module tb_demux_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lane_en = 8'hFF;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [7:0] out_valid;
  logic [7:0] out_ready = 8'hFF;
  logic [7:0] out_data;
  logic [2:0] out_sel;

  typedef struct packed {
    logic [2:0] lane;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  demux_sched #(.W(8)) dut (
    .clk(clk), .reset(reset), .lane_en(lane_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_beat(input logic [2:0] lane, input logic [7:0] data);
    exp_t e;
    e.lane = lane;
    e.data = data;
    sb.push_back(e);
    in_valid = 1'b1;
    in_data = data;
  endtask

  task automatic test_reset();
    lane_en = 8'hFF;
    out_ready = 8'hFF;
    do_reset();
    #1;
    compared++;
    if (out_valid !== 8'h00 || out_sel !== 3'd0 || out_data !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got valid=%h sel=%0d data=%h, want 00/0/00", out_valid, out_sel, out_data);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    lane_en = 8'h00;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_no_lanes: got in_ready=%b, want 0", in_ready);
    end
    lane_en = 8'hFF;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    lane_en = 8'hFF;
    out_ready = 8'hFF;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      push_beat(3'(k % 8), 8'(8'hA0 + k));
      #1;
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL b2b_in_ready beat %0d: got %b, want 1", k, in_ready);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (out_valid !== (8'h01 << e.lane) || out_data !== e.data) begin
        mismatched++;
        $display("[TB] FAIL b2b_beat %0d: got valid=%h data=%h, want %h/%h", k, out_valid, out_data, 8'h01 << e.lane, e.data);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL b2b_drain: got valid=%h, want 00", out_valid);
    end
  endtask

  task automatic test_lane_mask();
    exp_t e;
    logic [2:0] lanes [4] = '{3'd0, 3'd2, 3'd5, 3'd0};
    out_ready = 8'hFF;
    lane_en = 8'hFF;
    do_reset();
    lane_en = 8'b0010_0101;
    for (int k = 0; k < 4; k++) begin
      push_beat(lanes[k], 8'(8'h50 + k));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (out_valid !== (8'h01 << e.lane) || out_sel !== e.lane || out_data !== e.data) begin
        mismatched++;
        $display("[TB] FAIL mask_beat %0d: got valid=%h sel=%0d data=%h, want sel=%0d data=%h", k, out_valid, out_sel, out_data, e.lane, e.data);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    exp_t e;
`ifdef DEMUX_SCHED_SKIP_EN
    logic [2:0] lanes [3] = '{3'd0, 3'd2, 3'd3};
`else
    logic [2:0] lanes [3] = '{3'd0, 3'd1, 3'd2};
`endif
    lane_en = 8'hFF;
    out_ready = 8'hFF;
    do_reset();
    out_ready = 8'hFD;
    for (int k = 0; k < 3; k++) begin
      push_beat(lanes[k], 8'(8'hC0 + k));
      #1;
`ifndef DEMUX_SCHED_SKIP_EN
      if (k == 2) begin
        compared++;
        if (in_ready !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL stall_blocked: got in_ready=%b, want 0", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
          @(posedge clk);
          #1;
          compared++;
          if (out_valid !== 8'h02 || out_data !== 8'hC1 || in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL stall_hold cycle %0d: got valid=%h data=%h rdy=%b, want 02/c1/0", c, out_valid, out_data, in_ready);
          end
        end
        out_ready = 8'hFF;
        #1;
      end
`endif
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL stall_in_ready beat %0d: got %b, want 1", k, in_ready);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if (out_valid !== (8'h01 << e.lane) || out_data !== e.data) begin
        mismatched++;
        $display("[TB] FAIL stall_beat %0d: got valid=%h data=%h, want %h/%h", k, out_valid, out_data, 8'h01 << e.lane, e.data);
      end
    end
    in_valid = 1'b0;
    out_ready = 8'hFF;
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL stall_drain: got valid=%h, want 00", out_valid);
    end
  endtask

  task automatic test_disable_hold();
    exp_t e;
    lane_en = 8'hFF;
    out_ready = 8'h00;
    do_reset();
    lane_en = 8'h08;
    push_beat(3'd3, 8'h33);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (out_valid !== (8'h01 << e.lane) || out_data !== e.data) begin
      mismatched++;
      $display("[TB] FAIL hold_load: got valid=%h data=%h, want %h/%h", out_valid, out_data, 8'h01 << e.lane, e.data);
    end
    in_valid = 1'b0;
    lane_en = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 8'h08 || in_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold_disabled cycle %0d: got valid=%h rdy=%b, want 08/0", c, out_valid, in_ready);
      end
    end
    out_ready = 8'h08;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL hold_rdy_no_lanes: got in_ready=%b, want 0", in_ready);
    end
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 8'h00 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL hold_release: got valid=%h rdy=%b, want 00/0", out_valid, in_ready);
    end
    lane_en = 8'hFF;
    out_ready = 8'hFF;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    lane_en = 8'hFF;
    out_ready = 8'h00;
    do_reset();
    lane_en = 8'h10;
    push_beat(3'd4, 8'h44);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (out_valid !== (8'h01 << e.lane) || out_data !== e.data) begin
      mismatched++;
      $display("[TB] FAIL midrst_load: got valid=%h data=%h, want %h/%h", out_valid, out_data, 8'h01 << e.lane, e.data);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 8'h00 || out_sel !== 3'd0 || out_data !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL midrst_clear: got valid=%h sel=%0d data=%h, want 00/0/00", out_valid, out_sel, out_data);
    end
    reset = 1'b0;
    lane_en = 8'hFF;
    out_ready = 8'hFF;
    push_beat(3'd0, 8'h5A);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (out_valid !== (8'h01 << e.lane) || out_data !== e.data) begin
      mismatched++;
      $display("[TB] FAIL midrst_first: got valid=%h data=%h, want %h/%h", out_valid, out_data, 8'h01 << e.lane, e.data);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap_no_bubble();
    exp_t e;
    lane_en = 8'hFF;
    out_ready = 8'hFF;
    do_reset();
    lane_en = 8'h80;
    push_beat(3'd7, 8'h77);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (out_valid !== (8'h01 << e.lane) || out_data !== e.data) begin
      mismatched++;
      $display("[TB] FAIL wrap_lane7: got valid=%h data=%h, want %h/%h", out_valid, out_data, 8'h01 << e.lane, e.data);
    end
    lane_en = 8'hFF;
    push_beat(3'd0, 8'h88);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wrap_in_ready: got %b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (out_valid !== (8'h01 << e.lane) || out_data !== e.data) begin
      mismatched++;
      $display("[TB] FAIL wrap_lane0: got valid=%h data=%h, want %h/%h", out_valid, out_data, 8'h01 << e.lane, e.data);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lane_mask();
    test_stall();
    test_disable_hold();
    test_reset_mid();
    test_wrap_no_bubble();
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
